// File: rtl/reorder_buffer.sv
// Reorder buffer for the rename/decode interface.
// It hands out entry IDs to the dispatch lanes and records the two physical
// register aliases that each instruction displaced. It marks entries done as
// the execution units complete them, and retires up to RETIRE entries per
// cycle in program order. The displaced aliases of retired entries are
// returned on free_regs.
module reorder_buffer #(
  parameter  int DEPTH     = 32,
  parameter  int WIDTH     = 4,
  parameter  int RETIRE    = 3,
  parameter  int CMPL      = 4,
  parameter  int PR_ADDR_W = 5,
  localparam int ID_W      = $clog2(DEPTH),
  localparam int AL_W      = 2 * PR_ADDR_W,
  localparam int CNT_W     = ID_W + 1,
  localparam int RC_W      = $clog2(RETIRE + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [ID_W*WIDTH-1:0]   alloc_ids,
  output logic [WIDTH-1:0]        dispatch_ready,
  input  logic [WIDTH-1:0]        dispatch_valid,
  input  logic [AL_W*WIDTH-1:0]   dispatch_old_aliases,
  input  logic [CMPL-1:0]         cmpl_valid,
  input  logic [ID_W*CMPL-1:0]    cmpl_id,
  input  logic                    flush,
  output logic [AL_W*RETIRE-1:0]  free_regs,
  output logic [RC_W-1:0]         retire_count,
  output logic [CNT_W-1:0]        occupancy
);

  localparam int ACC_W = $clog2(WIDTH + 1);

  logic [ID_W-1:0]         head;
  logic [ID_W-1:0]         tail;
  logic [CNT_W-1:0]        count;
  logic [DEPTH-1:0]        busy;
  logic [DEPTH-1:0]        done;
  logic [AL_W-1:0]         alias_mem [DEPTH];

  logic [DEPTH-1:0]        busy_nxt;
  logic [DEPTH-1:0]        done_nxt;
  logic [ACC_W-1:0]        acc_cnt;
  logic [RC_W-1:0]         ret_n;
  logic [AL_W*RETIRE-1:0]  free_nxt;
  logic [CNT_W-1:0]        free_slots;
  logic                    acc_gap;
  logic                    ret_stop;

  assign occupancy  = count;
  assign free_slots = CNT_W'(DEPTH) - count;

  // Lane IDs and readiness come straight from the registered tail and count;
  // space freed by retirements in this cycle is not offered until next cycle.
  always_comb begin
    alloc_ids      = '0;
    dispatch_ready = '0;
    for (int i = 0; i < WIDTH; i++) begin
      alloc_ids[i*ID_W +: ID_W] = tail + ID_W'(i);
      dispatch_ready[i]         = (free_slots > CNT_W'(i));
    end
  end

  // Accept the longest run of valid-and-ready lanes starting at lane 0.
  // Lanes after the first gap are dropped.
  always_comb begin
    acc_cnt = '0;
    acc_gap = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!acc_gap && dispatch_valid[i] && dispatch_ready[i]) begin
        acc_cnt = acc_cnt + ACC_W'(1);
      end else begin
        acc_gap = 1'b1;
      end
    end
  end

  // Count the consecutive busy-and-done entries from head, up to RETIRE.
  // An empty ROB has no busy entries, so it yields zero.
  always_comb begin
    ret_n    = '0;
    ret_stop = 1'b0;
    for (int s = 0; s < RETIRE; s++) begin
      if (!ret_stop && busy[head + ID_W'(s)] && done[head + ID_W'(s)]) begin
        ret_n = ret_n + RC_W'(1);
      end else begin
        ret_stop = 1'b1;
      end
    end
  end

  // Gather the aliases of the retiring entries. Unused slots stay zero.
  always_comb begin
    free_nxt = '0;
    for (int s = 0; s < RETIRE; s++) begin
      if (RC_W'(s) < ret_n) begin
        free_nxt[s*AL_W +: AL_W] = alias_mem[head + ID_W'(s)];
      end
    end
  end

  // Build the next entry flags. Completions land only on busy entries.
  // Retirement then clears its entries. Fresh dispatches claim slots that
  // were free at the start of the cycle. Flush wipes everything.
  always_comb begin
    busy_nxt = busy;
    done_nxt = done;
    for (int p = 0; p < CMPL; p++) begin
      if (cmpl_valid[p] && busy[cmpl_id[p*ID_W +: ID_W]]) begin
        done_nxt[cmpl_id[p*ID_W +: ID_W]] = 1'b1;
      end
    end
    for (int s = 0; s < RETIRE; s++) begin
      if (RC_W'(s) < ret_n) begin
        busy_nxt[head + ID_W'(s)] = 1'b0;
        done_nxt[head + ID_W'(s)] = 1'b0;
      end
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (ACC_W'(i) < acc_cnt) begin
        busy_nxt[tail + ID_W'(i)] = 1'b1;
        done_nxt[tail + ID_W'(i)] = 1'b0;
      end
    end
    if (flush) begin
      busy_nxt = '0;
      done_nxt = '0;
    end
  end

  // Control state and the registered retirement outputs.
  // Flush returns everything to the empty state on the next edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      busy         <= '0;
      done         <= '0;
      free_regs    <= '0;
      retire_count <= '0;
    end else if (flush) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      busy         <= busy_nxt;
      done         <= done_nxt;
      free_regs    <= '0;
      retire_count <= '0;
    end else begin
      head         <= head + ID_W'(ret_n);
      tail         <= tail + ID_W'(acc_cnt);
      count        <= count + CNT_W'(acc_cnt) - CNT_W'(ret_n);
      busy         <= busy_nxt;
      done         <= done_nxt;
      free_regs    <= free_nxt;
      retire_count <= ret_n;
    end
  end

  // Alias storage is written on dispatch only; busy qualifies its contents,
  // so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (!flush && (ACC_W'(i) < acc_cnt)) begin
        alias_mem[tail + ID_W'(i)] <= dispatch_old_aliases[i*AL_W +: AL_W];
      end
    end
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement end of the rename/decode interface. Allocates ROB entry IDs to the decoder, records the two superseded physical-register aliases each dispatched instruction displaced, collects completion marks from the execution units, and retires up to three instructions per cycle in program order. Retirement returns the displaced aliases to the decoder's free pool via `free_regs`.

## Interface
- `DEPTH`, 32: number of ROB entries. Must be a power of two. ID width is 5 for the default.
- `WIDTH`, 4: dispatch lanes. Matches the decoder width.
- `RETIRE`, 3: maximum retirements per cycle.
- `CMPL`, 4: completion ports.
- `PR_ADDR_W`, 5: physical register address width.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous reset, active-low (0 = reset).
- `alloc_ids`  out  5*WIDTH  IDs offered to dispatch lanes. Lane i gets `tail+i` mod DEPTH.
- `dispatch_ready`  out  WIDTH  lane i ready iff free entries > i.
- `dispatch_valid`  in  WIDTH  lane i dispatches this cycle.
- `dispatch_old_aliases`  in  2*PR_ADDR_W*WIDTH  per lane, two displaced physical regs. Value 0 or 1 means none.
- `cmpl_valid`  in  CMPL  completion strobe per port.
- `cmpl_id`  in  5*CMPL  ROB ID completing.
- `flush`  in  1  synchronous discard of all entries.
- `free_regs`  out  2*PR_ADDR_W*RETIRE  registered, the aliases released this cycle. Unused slots are 0.
- `retire_count`  out  2  registered count of instructions retired.
- `occupancy`  out  6  registered count of live entries (0..DEPTH).

## Operation
- State:
  - `head` (oldest entry), `tail` (next entry to allocate), `count`.
  - Per entry: `busy`, `done`, and the 10-bit `old_alias`.
- Dispatch:
  - Accepted lanes are the longest prefix from lane 0 with `dispatch_valid[i] & dispatch_ready[i]`.
  - Any lane after the first gap is ignored. This is a protocol error; the bench flags it.
  - Each accepted lane k writes entry `tail+k`: busy=1, done=0, and `old_alias` = the lane's pair.
  - `tail` advances by the accepted count.
- Completion:
  - For each valid port, set `done` on entry `cmpl_id` only if that entry is busy.
  - Completion for a non-busy ID is dropped silently.
  - Duplicate IDs across ports are harmless.
- Retire:
  - Evaluated from registered state each cycle.
  - Retire n = the number of consecutive entries from `head` that are busy & done, capped at RETIRE.
  - Retired entries are cleared (busy=0, done=0) and `head` advances by n.
  - Slot s<n of `free_regs` gets entry `head+s`'s `old_alias`; slots ≥ n are 0.
- Count:
  - `count_next = count + accepted − n`.
  - `dispatch_ready` uses `count` at the start of the cycle. Same-cycle retirements do not free space early.
- Pointers wrap modulo DEPTH.
- Flush:
  - Clears all busy/done bits, sets `head=tail=0` and `count=0`.
  - Forces `free_regs=0` and `retire_count=0` next cycle.
  - Flush has priority over same-cycle dispatch, completion and retire.

## Timing
- Reset values: `head=tail=count=0`; all busy/done=0; `free_regs=0`; `retire_count=0`; `occupancy=0`; `alloc_ids={3,2,1,0}`; `dispatch_ready=4'b1111`.
- `alloc_ids` and `dispatch_ready` are combinational from registered pointers and count.
- Dispatch in cycle t: the entry is busy at t+1 and can accept completion from t+1.
- Completion in cycle t: done at t+1, retire decision in t+1, `free_regs`/`retire_count` visible at t+2.
- Retirement is at most RETIRE per cycle, strictly in order. A not-done entry at `head` blocks everything behind it.
- Full (count=DEPTH): `dispatch_ready=0`. Empty (count=0): n=0.
- Asserting `rst` low mid-operation clears state immediately, independent of `clk`. Deassertion takes effect on the next rising edge.

## Test plan
- Reset, then dispatch 4 lanes with aliases {2,3},{4,5},{6,7},{8,9}:
  - `alloc_ids` next cycle = {7,6,5,4}.
  - `occupancy`=4.
- Complete IDs 0, 1, 2, 3 in one cycle:
  - Two cycles later `retire_count`=3 and `free_regs` = {6,7},{4,5},{2,3}.
  - The cycle after, `retire_count`=1 and `free_regs` slot 0 = {8,9}.
- Complete ID 1 only, leaving ID 0 not done:
  - Expect `retire_count`=0 until ID 0 completes.
  - Then IDs 0 and 1 retire together.
- Fill to 32 entries:
  - `dispatch_ready`=0; dispatch attempts are ignored and `occupancy` stays 32.
  - Retiring 3 gives `dispatch_ready=4'b0111`.
  - Wrap: `alloc_ids` lane 0 = 0 after `tail` passes 31.
- Issue a completion to an unallocated ID 10 with the ROB empty:
  - No state change.
  - A later dispatch into ID 10 starts with done=0.
- Assert `flush` with 5 live entries while simultaneously dispatching:
  - Next cycle `occupancy`=0, `alloc_ids={3,2,1,0}`, `free_regs=0`.
- Assert `rst` low asynchronously mid-retire:
  - All outputs return to reset values before the next edge.
